// File: rtl/eq2.sv
// eq2 - 2-bit equality comparator with a registered status side path.
//
// The combinational output aeqb depends only on the operands. The registered
// path samples a/b on every rising clk and produces delayed compare flags, a
// rising-edge pulse on equality and a saturating count of equal samples.
//
// Ports
//   clk       in   system clock, rising-edge
//   reset     in   synchronous, active-high reset
//   a, b      in   2-bit unsigned operands
//   aeqb      out  combinational a == b
//   aeqb_q    out  registered a == b
//   agtb_q    out  registered a > b (unsigned)
//   altb_q    out  registered a < b (unsigned)
//   eq_rise   out  one-cycle pulse when equality goes 0 -> 1
//   eq_count  out  saturating count of edges sampled with a == b
module eq2 #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       a,
  input  logic [1:0]       b,
  output logic             aeqb,
  output logic             aeqb_q,
  output logic             agtb_q,
  output logic             altb_q,
  output logic             eq_rise,
  output logic [CNT_W-1:0] eq_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic eq_now;
  logic gt_now;
  logic lt_now;

  // Bitwise XNOR form keeps aeqb free of any clock or reset dependence.
  assign eq_now = ~(a[1] ^ b[1]) & ~(a[0] ^ b[0]);
  assign aeqb   = eq_now;

  // Unsigned magnitude compare: the high bit decides unless the high bits match.
  assign gt_now = (a[1] & ~b[1]) | (~(a[1] ^ b[1]) & a[0] & ~b[0]);
  assign lt_now = (~a[1] & b[1]) | (~(a[1] ^ b[1]) & ~a[0] & b[0]);

  always_ff @(posedge clk) begin
    if (reset) begin
      aeqb_q   <= 1'b0;
      agtb_q   <= 1'b0;
      altb_q   <= 1'b0;
      eq_rise  <= 1'b0;
      eq_count <= '0;
    end else begin
      aeqb_q  <= eq_now;
      agtb_q  <= gt_now;
      altb_q  <= lt_now;
      // Compared against the previous registered flag, so the first equal
      // sample after reset always pulses.
      eq_rise <= eq_now & ~aeqb_q;
      if (eq_now && (eq_count != CNT_MAX)) begin
        eq_count <= eq_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_eq2.sv
module tb_eq2;

  logic       clk;
  logic       clk_en;
  logic       reset;
  logic [1:0] a;
  logic [1:0] b;
  logic       aeqb;
  logic       aeqb_q;
  logic       agtb_q;
  logic       altb_q;
  logic       eq_rise;
  logic [7:0] eq_count;

  int n_tests;
  int n_fail;

  // Reference state, kept as plain integers/booleans.
  int m_prev_eq;
  int m_eq;
  int m_gt;
  int m_lt;
  int m_rise;
  int m_cnt;

  eq2 #(.CNT_W(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .a        (a),
    .b        (b),
    .aeqb     (aeqb),
    .aeqb_q   (aeqb_q),
    .agtb_q   (agtb_q),
    .altb_q   (altb_q),
    .eq_rise  (eq_rise),
    .eq_count (eq_count)
  );

  initial begin
    clk = 1'b0;
    forever begin
      #5;
      if (clk_en) clk = ~clk;
    end
  end

  // One clocked step: drive on the low phase, check 1 time unit after the edge.
  task automatic step(input logic [1:0] ta, input logic [1:0] tb, input logic tr);
    int ia, ib;
    logic [7:0] exp_cnt;
    @(negedge clk);
    a = ta;
    b = tb;
    reset = tr;
    @(posedge clk);
    #1;
    ia = int'(ta);
    ib = int'(tb);
    if (tr) begin
      m_eq = 0; m_gt = 0; m_lt = 0; m_rise = 0; m_cnt = 0;
    end else begin
      m_rise = (ia == ib && m_prev_eq == 0) ? 1 : 0;
      m_eq   = (ia == ib) ? 1 : 0;
      m_gt   = (ia > ib) ? 1 : 0;
      m_lt   = (ia < ib) ? 1 : 0;
      if (ia == ib) m_cnt = (m_cnt + 1 > 255) ? 255 : m_cnt + 1;
    end
    m_prev_eq = m_eq;
    exp_cnt = m_cnt[7:0];

    n_tests++;
    if (aeqb_q !== m_eq[0]) begin
      n_fail++;
      $display("FAIL aeqb_q a=%0d b=%0d rst=%0b: got %b want %0d", ta, tb, tr, aeqb_q, m_eq);
    end
    n_tests++;
    if (agtb_q !== m_gt[0]) begin
      n_fail++;
      $display("FAIL agtb_q a=%0d b=%0d rst=%0b: got %b want %0d", ta, tb, tr, agtb_q, m_gt);
    end
    n_tests++;
    if (altb_q !== m_lt[0]) begin
      n_fail++;
      $display("FAIL altb_q a=%0d b=%0d rst=%0b: got %b want %0d", ta, tb, tr, altb_q, m_lt);
    end
    n_tests++;
    if (eq_rise !== m_rise[0]) begin
      n_fail++;
      $display("FAIL eq_rise a=%0d b=%0d rst=%0b: got %b want %0d", ta, tb, tr, eq_rise, m_rise);
    end
    n_tests++;
    if (eq_count !== exp_cnt) begin
      n_fail++;
      $display("FAIL eq_count a=%0d b=%0d rst=%0b: got %0d want %0d", ta, tb, tr, eq_count, exp_cnt);
    end
    n_tests++;
    if (aeqb !== (ta == tb)) begin
      n_fail++;
      $display("FAIL aeqb_clocked a=%0d b=%0d: got %b want %b", ta, tb, aeqb, (ta == tb));
    end
    if (!tr) begin
      n_tests++;
      if ((32'(aeqb_q) + 32'(agtb_q) + 32'(altb_q)) !== 32'd1) begin
        n_fail++;
        $display("FAIL onehot a=%0d b=%0d: got eq/gt/lt=%b%b%b want exactly one set",
                 ta, tb, aeqb_q, agtb_q, altb_q);
      end
    end
  endtask

  task automatic test_comb_sweep();
    logic [1:0] va [7];
    logic [1:0] vb [7];
    logic       ve [7];
    va = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b10, 2'b11, 2'b11};
    vb = '{2'b00, 2'b00, 2'b11, 2'b10, 2'b00, 2'b11, 2'b01};
    ve = '{1'b1,  1'b0,  1'b0,  1'b1,  1'b0,  1'b1,  1'b0};
    clk_en = 1'b0;
    for (int i = 0; i < 7; i++) begin
      a = va[i];
      b = vb[i];
      #200;
      n_tests++;
      if (aeqb !== ve[i]) begin
        n_fail++;
        $display("FAIL comb_sweep a=%b b=%b: got %b want %b", va[i], vb[i], aeqb, ve[i]);
      end
    end
    clk_en = 1'b1;
  endtask

  task automatic test_reset();
    step(2'b10, 2'b10, 1'b1);
    step(2'b10, 2'b10, 1'b1);
    n_tests++;
    if (aeqb_q !== 1'b0 || agtb_q !== 1'b0 || altb_q !== 1'b0 || eq_rise !== 1'b0 || eq_count !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_state: got eq/gt/lt/rise=%b%b%b%b cnt=%0d want 0000 cnt=0",
               aeqb_q, agtb_q, altb_q, eq_rise, eq_count);
    end
    step(2'b10, 2'b10, 1'b0);
    n_tests++;
    if (eq_rise !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release_rise: got %b want 1", eq_rise);
    end
    step(2'b10, 2'b10, 1'b0);
    n_tests++;
    if (eq_rise !== 1'b0 || eq_count !== 8'd2) begin
      n_fail++;
      $display("FAIL reset_release_next: got rise=%b cnt=%0d want rise=0 cnt=2", eq_rise, eq_count);
    end
  endtask

  task automatic test_exhaustive();
    for (int i = 0; i < 16; i++) begin
      step(2'(i >> 2), 2'(i & 3), 1'b0);
    end
  endtask

  task automatic test_edge_pulse();
    logic [1:0] sa [4];
    logic [1:0] sb [4];
    logic       sr [4];
    sa = '{2'b00, 2'b00, 2'b01, 2'b11};
    sb = '{2'b00, 2'b00, 2'b00, 2'b11};
    sr = '{1'b1,  1'b0,  1'b0,  1'b1};
    step(2'b01, 2'b10, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(sa[i], sb[i], 1'b0);
      n_tests++;
      if (eq_rise !== sr[i]) begin
        n_fail++;
        $display("FAIL edge_pulse[%0d]: got %b want %b", i, eq_rise, sr[i]);
      end
    end
  endtask

  task automatic test_saturation();
    logic [1:0] v;
    step(2'b00, 2'b00, 1'b1);
    for (int i = 0; i < 300; i++) begin
      v = 2'($urandom_range(0, 3));
      step(v, v, 1'b0);
    end
    n_tests++;
    if (eq_count !== 8'd255) begin
      n_fail++;
      $display("FAIL saturate: got %0d want 255", eq_count);
    end
    for (int i = 0; i < 5; i++) begin
      v = 2'($urandom_range(0, 3));
      step(v, v ^ 2'($urandom_range(1, 3)), 1'b0);
    end
    n_tests++;
    if (eq_count !== 8'd255) begin
      n_fail++;
      $display("FAIL saturate_hold: got %0d want 255", eq_count);
    end
  endtask

  task automatic test_reset_mid_count();
    step(2'b01, 2'b01, 1'b1);
    for (int i = 0; i < 10; i++) step(2'b01, 2'b01, 1'b0);
    n_tests++;
    if (eq_count !== 8'd10) begin
      n_fail++;
      $display("FAIL mid_count_pre: got %0d want 10", eq_count);
    end
    step(2'b01, 2'b01, 1'b1);
    n_tests++;
    if (eq_count !== 8'd0) begin
      n_fail++;
      $display("FAIL mid_count_reset: got %0d want 0", eq_count);
    end
    step(2'b11, 2'b11, 1'b0);
    n_tests++;
    if (eq_count !== 8'd1) begin
      n_fail++;
      $display("FAIL mid_count_resume: got %0d want 1", eq_count);
    end
  endtask

  task automatic test_random();
    logic [1:0] ra, rb;
    logic       rr;
    for (int i = 0; i < 300; i++) begin
      ra = 2'($urandom_range(0, 3));
      rb = ($urandom_range(0, 2) == 0) ? ra : 2'($urandom_range(0, 3));
      rr = ($urandom_range(0, 40) == 0);
      step(ra, rb, rr);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail = 0;
    m_prev_eq = 0; m_eq = 0; m_gt = 0; m_lt = 0; m_rise = 0; m_cnt = 0;
    clk_en = 1'b0;
    reset = 1'b1;
    a = 2'b00;
    b = 2'b00;
    test_comb_sweep();
    test_reset();
    test_exhaustive();
    test_edge_pulse();
    test_saturation();
    test_reset_mid_count();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
